// File: rtl/robo_pkg.sv
// Shared definitions for the pipe-cleaning robot controller and its bench.
package robo_pkg;

  // Controller FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SENSE  = 3'd1,
    ACT    = 3'd2,
    REMOVE = 3'd3,
    DONE   = 3'd4,
    STUCK  = 3'd5
  } state_t;

  // Action chosen in SENSE and carried into ACT/REMOVE.
  typedef enum logic [1:0] {
    ACT_FRONT  = 2'd0,
    ACT_TURN   = 2'd1,
    ACT_REMOVE = 2'd2
  } action_t;

  // Heading codes, kept here so map-driven benches share one encoding.
  localparam logic [1:0] NORTH = 2'b00;
  localparam logic [1:0] SOUTH = 2'b01;
  localparam logic [1:0] EAST  = 2'b10;
  localparam logic [1:0] WEST  = 2'b11;

endpackage

// File: rtl/robo_remove_timer.sv
// Down-counter that times how long the removal tool stays active.
// Loaded with REMOVE_CYCLES on entry to REMOVE; 'last' marks the final cycle.
module robo_remove_timer #(
  parameter int REMOVE_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic active,
  output logic last
);

  localparam int            CW       = $clog2(REMOVE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(REMOVE_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on request, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register, cleared asynchronously so a reset aborts any burst.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);
  assign last   = (cnt_q == ONE);

endmodule

// File: rtl/robo_limpa_tubos_ctrl.sv
// Pipe-cleaning robot controller: left-hand wall follower with a per-session
// move budget, timed debris/barrier removal and stall detection.
//
// Handshake: sensors_valid is a one-way valid with no ready. A sample is taken
// only on a rising edge where the FSM is in SENSE and sensors_valid is high;
// in every other state it is dropped. Each completed action (front, turn, or
// the last cycle of a removal burst) is marked by a one-cycle act_valid pulse
// that coincides with the action output, and the FSM returns to SENSE on the
// same edge, so the producer may present the next sample in the pulse cycle.
module robo_limpa_tubos_ctrl
  import robo_pkg::*;
#(
  parameter int REMOVE_CYCLES = 3,
  parameter int MOVE_W        = 9,
  parameter int STALL_LIMIT   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [MOVE_W-1:0] move_budget,
  input  logic              sensors_valid,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  output logic              front,
  output logic              turn,
  output logic              remove,
  output logic              act_valid,
  output logic              busy,
  output logic              done,
  output logic              stuck,
  output logic [MOVE_W-1:0] move_count,
  output state_t            state_o
);

  localparam int                TW        = $clog2(STALL_LIMIT + 1);
  localparam logic [TW-1:0]     STALL_MAX = TW'(STALL_LIMIT);
  localparam logic [TW-1:0]     TURN_ONE  = TW'(1);
  localparam logic [MOVE_W-1:0] MOVE_ONE  = MOVE_W'(1);

  state_t            state_q, state_d;
  action_t           action_q, action_d;
  logic [MOVE_W-1:0] budget_q, budget_d;
  logic [MOVE_W-1:0] move_cnt_q, move_cnt_d;
  logic [TW-1:0]     turns_q, turns_d;
  logic              just_turned_q, just_turned_d;
  logic              front_q, front_d;
  logic              turn_q, turn_d;
  logic              remove_q, remove_d;
  logic              act_valid_q, act_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stuck_q, stuck_d;

  logic timer_load;
  logic timer_active;
  logic timer_last;

  robo_remove_timer #(
    .REMOVE_CYCLES(REMOVE_CYCLES)
  ) u_remove_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .active(timer_active),
    .last  (timer_last)
  );

  // Next-state, counter updates and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    action_d      = action_q;
    budget_d      = budget_q;
    move_cnt_d    = move_cnt_q;
    turns_d       = turns_q;
    just_turned_d = just_turned_q;
    timer_load    = 1'b0;
    front_d       = 1'b0;
    turn_d        = 1'b0;
    remove_d      = 1'b0;
    act_valid_d   = 1'b0;

    case (state_q)
      IDLE, DONE, STUCK: begin
        if (start) begin
          budget_d      = move_budget;
          move_cnt_d    = '0;
          turns_d       = '0;
          just_turned_d = 1'b0;
          state_d       = (move_budget == '0) ? DONE : SENSE;
        end
      end

      SENSE: begin
        if (sensors_valid) begin
          if (under || barrier) begin
            action_d   = ACT_REMOVE;
            state_d    = REMOVE;
            timer_load = 1'b1;
          end else if (!left && !just_turned_q) begin
            action_d = ACT_TURN;
            state_d  = ACT;
          end else if (!head) begin
            action_d = ACT_FRONT;
            state_d  = ACT;
          end else begin
            action_d = ACT_TURN;
            state_d  = ACT;
          end
        end
      end

      ACT: begin
        act_valid_d = 1'b1;
        if (action_q == ACT_FRONT) begin
          front_d       = 1'b1;
          move_cnt_d    = move_cnt_q + MOVE_ONE;
          turns_d       = '0;
          just_turned_d = 1'b0;
        end else begin
          turn_d        = 1'b1;
          turns_d       = turns_q + TURN_ONE;
          just_turned_d = 1'b1;
        end
        // Budget exhaustion takes precedence over a simultaneous stall.
        if (move_cnt_d == budget_q) begin
          state_d = DONE;
        end else if (turns_d == STALL_MAX) begin
          state_d = STUCK;
        end else begin
          state_d = SENSE;
        end
      end

      REMOVE: begin
        remove_d = timer_active;
        if (timer_last) begin
          act_valid_d = 1'b1;
          state_d     = SENSE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == SENSE) || (state_d == ACT) || (state_d == REMOVE);
    done_d  = (state_d == DONE);
    stuck_d = (state_d == STUCK);
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      action_q      <= ACT_FRONT;
      budget_q      <= '0;
      move_cnt_q    <= '0;
      turns_q       <= '0;
      just_turned_q <= 1'b0;
      front_q       <= 1'b0;
      turn_q        <= 1'b0;
      remove_q      <= 1'b0;
      act_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      action_q      <= action_d;
      budget_q      <= budget_d;
      move_cnt_q    <= move_cnt_d;
      turns_q       <= turns_d;
      just_turned_q <= just_turned_d;
      front_q       <= front_d;
      turn_q        <= turn_d;
      remove_q      <= remove_d;
      act_valid_q   <= act_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      stuck_q       <= stuck_d;
    end
  end

  assign front      = front_q;
  assign turn       = turn_q;
  assign remove     = remove_q;
  assign act_valid  = act_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stuck      = stuck_q;
  assign move_count = move_cnt_q;
  assign state_o    = state_q;

endmodule
